// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared states and sizing constants for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

   localparam int IMEM_BYTES = 4096;
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   // States in which a frame is in flight and stream bytes are accepted.
   function automatic logic is_busy(input state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte stream, memory write and status bundle of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  Start;
   logic                  InValid;
   logic [7:0]            InData;
   logic                  InReady;
   logic                  MemWrite;
   logic [ADDR_WIDTH-1:0] MemAddress;
   logic [31:0]           MemData;
   logic                  CpuHold;
   logic                  Busy;
   logic                  Done;
   logic                  Error;
   logic [10:0]           WordCount;

   modport master (
      output Start, InValid, InData,
      input  InReady, MemWrite, MemAddress, MemData,
      input  CpuHold, Busy, Done, Error, WordCount
   );

   modport slave (
      input  Start, InValid, InData,
      output InReady, MemWrite, MemAddress, MemData,
      output CpuHold, Busy, Done, Error, WordCount
   );
endinterface

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// Module      : imem_word_packer
// Description : Packs four stream bytes big-endian into a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        word_last
);

   logic [1:0] byte_cnt;

   assign word_last = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

   // Shifting left puts the first byte of a word in bits 31:24.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt   <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else if (clear) begin
         byte_cnt   <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= word_last;
         if (byte_valid) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot-time framed byte stream to instruction memory word writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_WORDS  = IMEM_BYTES / WORD_BYTES
)(
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  bus
);

   state_t                state;
   state_t                state_nxt;
   logic                  busy;
   logic                  start_ok;
   logic                  accept;
   logic                  data_byte;
   logic                  len_ok;
   logic                  final_word;
   logic                  word_last;
   logic                  word_valid;
   logic [15:0]           len_full;
   logic [7:0]            len_hi;
   logic [7:0]            csum;
   logic [10:0]           n_words;
   logic [10:0]           word_cnt;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           word;

   assign accept     = bus.InValid && busy;
   assign data_byte  = accept && (state == DATA);
   assign len_full   = {len_hi, bus.InData};
   assign len_ok     = (len_full != 16'd0) && (len_full <= 16'(MAX_WORDS));
   assign final_word = word_last && ((word_cnt + 11'd1) == n_words);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = is_busy(state);
      start_ok  = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (bus.Start) begin
               start_ok  = 1'b1;
               state_nxt = LEN_HI;
            end
         end
         LEN_HI: if (accept) state_nxt = LEN_LO;
         LEN_LO: if (accept) state_nxt = len_ok ? DATA : ERROR;
         DATA:   if (final_word) state_nxt = CSUM;
         CSUM:   if (accept) state_nxt = (bus.InData == csum) ? DONE : ERROR;
         default: state_nxt = IDLE;
      endcase
   end

   // Address and count advance on the 4th byte so they line up with the write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi   <= 8'd0;
         n_words  <= 11'd0;
         csum     <= 8'd0;
         word_cnt <= 11'd0;
         mem_addr <= '0;
      end else begin
         if (start_ok) begin
            csum     <= 8'd0;
            word_cnt <= 11'd0;
         end
         if (accept && (state == LEN_HI)) len_hi <= bus.InData;
         if (accept && (state == LEN_LO)) n_words <= len_full[10:0];
         if (data_byte) csum <= csum ^ bus.InData;
         if (word_last) begin
            mem_addr <= {word_cnt[ADDR_WIDTH-3:0], 2'b00};
            word_cnt <= word_cnt + 11'd1;
         end
      end
   end

   imem_word_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok),
      .byte_valid (data_byte),
      .byte_in    (bus.InData),
      .word       (word),
      .word_valid (word_valid),
      .word_last  (word_last)
   );

   assign bus.InReady    = busy;
   assign bus.Busy       = busy;
   assign bus.CpuHold    = busy;
   assign bus.Done       = (state == DONE);
   assign bus.Error      = (state == ERROR);
   assign bus.MemWrite   = word_valid;
   assign bus.MemAddress = mem_addr;
   assign bus.MemData    = word;
   assign bus.WordCount  = word_cnt;

endmodule

`default_nettype wire
